// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The CR/LF bytes are used only when UART_TX_ARBITER_CRLF_EN is defined.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } arb_state_t;

    localparam logic [7:0] CR_BYTE = 8'h0D;
    localparam logic [7:0] LF_BYTE = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester after the last owner wins.
module txarb_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last_owner,
    output logic [NREQ-1:0]  o_pick
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // k runs 1..NREQ so the last owner itself is checked last
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDX_W'((32'(i_last_owner) + 32'(k)) % 32'(NREQ));
            if (!w_found && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding one UART transmitter core.
// Define UART_TX_ARBITER_CRLF_EN to append CR then LF after every message.
//
// state    | meaning
// IDLE     | no owner; waiting for any req_valid
// GRANT    | owner locked; waiting for a byte and an idle transmitter
// WAIT_HI  | tx_start just issued; transmitter raising tx_busy
// WAIT_LO  | byte in flight; waiting for tx_busy to fall
// SEND     | message finished; record last owner and release the grant
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        grant,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_byte,
    input  logic                   tx_busy,
    output logic                   arb_idle
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t          r_state;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_req_ready;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_byte;
    logic                r_arb_idle;
    logic [IDX_W-1:0]    r_last_owner;
    logic                r_last_byte;
`ifdef UART_TX_ARBITER_CRLF_EN
    logic [1:0]          r_crlf_step;
`endif

    logic [NREQ-1:0]     w_pick;
    logic [IDX_W-1:0]    w_owner;
    logic                w_owner_valid;
    logic                w_owner_last;
    logic [DATA_W-1:0]   w_owner_data;

    txarb_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req        (req_valid),
        .i_last_owner (r_last_owner),
        .o_pick       (w_pick)
    );

    always_comb begin
        w_owner       = '0;
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        w_owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_owner       = IDX_W'(i);
                w_owner_valid = req_valid[i];
                w_owner_last  = req_last[i];
                w_owner_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_req_ready  <= '0;
            r_tx_start   <= 1'b0;
            r_tx_byte    <= '0;
            r_arb_idle   <= 1'b1;
            r_last_owner <= IDX_W'(NREQ - 1);
            r_last_byte  <= 1'b0;
`ifdef UART_TX_ARBITER_CRLF_EN
            r_crlf_step  <= 2'd0;
`endif
        end else begin
            r_tx_start  <= 1'b0;
            r_req_ready <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant    <= w_pick;
                        r_arb_idle <= 1'b0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
`ifdef UART_TX_ARBITER_CRLF_EN
                    if (r_crlf_step != 2'd0) begin
                        if (!tx_busy) begin
                            r_tx_start <= 1'b1;
                            r_tx_byte  <= (r_crlf_step == 2'd1) ? DATA_W'(CR_BYTE) : DATA_W'(LF_BYTE);
                            r_state    <= ST_WAIT_HI;
                        end
                    end else
`endif
                    if (w_owner_valid && !tx_busy) begin
                        r_tx_start  <= 1'b1;
                        r_req_ready <= r_grant;
                        r_tx_byte   <= w_owner_data;
                        r_last_byte <= w_owner_last;
                        r_state     <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    r_state <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_last_byte) begin
`ifdef UART_TX_ARBITER_CRLF_EN
                            // grant stays locked through the appended CR and LF
                            if (r_crlf_step == 2'd2) begin
                                r_crlf_step <= 2'd0;
                                r_state     <= ST_SEND;
                            end else begin
                                r_crlf_step <= r_crlf_step + 2'd1;
                                r_state     <= ST_GRANT;
                            end
`else
                            r_state <= ST_SEND;
`endif
                        end else begin
                            r_state <= ST_GRANT;
                        end
                    end
                end
                ST_SEND: begin
                    r_last_owner <= w_owner;
                    r_grant      <= '0;
                    r_arb_idle   <= 1'b1;
                    r_last_byte  <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign grant     = r_grant;
    assign tx_start  = r_tx_start;
    assign tx_byte   = r_tx_byte;
    assign arb_idle  = r_arb_idle;

endmodule
